wb_mailbox: RTL and testbench

WB_MAILBOX -- requirements
Module: wb_mailbox

---
 rtl/wb_mailbox_pkg.sv | 28 ++
 rtl/mbx_fifo.sv | 57 +++++
 rtl/wb_mailbox.sv | 141 ++++++++++++++
 tb/tb_wb_mailbox.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_mailbox_pkg.sv
// Shared constants for the Wishbone mailbox: register offsets, STATUS/CTRL
// bit positions and the bus-handshake FSM states.
package wb_mailbox_pkg;

    // Word offsets taken from wbs_adr_i[3:2]
    localparam logic [1:0] OFF_DATA   = 2'd0;
    localparam logic [1:0] OFF_STATUS = 2'd1;
    localparam logic [1:0] OFF_CTRL   = 2'd2;
    localparam logic [1:0] OFF_RSVD   = 2'd3;

    localparam int ST_M2S_FULL  = 0;
    localparam int ST_M2S_EMPTY = 1;
    localparam int ST_S2M_FULL  = 2;
    localparam int ST_S2M_EMPTY = 3;
    localparam int ST_OVF       = 8;
    localparam int ST_UNF       = 9;
    localparam int ST_M2S_CNT   = 12;
    localparam int ST_S2M_CNT   = 16;

    localparam int CTRL_IRQ_EN  = 0;
    localparam int CTRL_FLUSH   = 1;

    typedef enum logic {
        S_IDLE,
        S_ACK
    } state_t;

endpackage

// File: rtl/mbx_fifo.sv
// Power-of-two FIFO with a show-ahead head output; push while full and pop
// while empty are ignored, and flush empties it regardless of push/pop.
module mbx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [4:0]       count
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      cnt;
    logic             do_push, do_pop;

    assign full    = (cnt == (AW+1)'(DEPTH));
    assign empty   = (cnt == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign count   = 5'(cnt);
    // Head reads as 0 when empty so downstream sees a clean value after reset/flush
    assign rdata   = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + (AW+1)'(1);
                2'b01:   cnt <= cnt - (AW+1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/wb_mailbox.sv
// Wishbone slave mailbox: a 4-word register window fronting one FIFO toward
// the SoC (m2s) and one from the SoC (s2m), with sticky error flags and an IRQ.
module wb_mailbox
    import wb_mailbox_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int          DEPTH     = 4
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_dat_i,
    input  logic [31:0] wbs_adr_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic [31:0] m2s_data_o,
    output logic        m2s_valid_o,
    input  logic        m2s_ready_i,
    input  logic [31:0] s2m_data_i,
    input  logic        s2m_valid_i,
    output logic        s2m_ready_o,
    output logic        irq_o
);
    state_t      state, next_state;
    logic        sel_hit, ack;
    logic [1:0]  off;
    logic        wr, rd, m2s_push, s2m_pop, ctrl_wr, st_wr, flush;
    logic        m2s_full, m2s_empty, s2m_full, s2m_empty;
    logic [4:0]  m2s_count, s2m_count;
    logic [31:0] s2m_head, status, rdata;
    logic        irq_en, ovf, unf;
    logic        unused;

    assign sel_hit = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:4] == BASE_ADDR[31:4]);

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) state <= S_IDLE;
        else          state <= next_state;
    end

    always_comb begin
        next_state = state;
        ack        = 1'b0;
        case (state)
            S_IDLE: if (sel_hit) next_state = S_ACK;
            S_ACK: begin
                ack        = 1'b1;
                next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    // All register side effects are qualified by ack, i.e. happen once per access
    assign off      = wbs_adr_i[3:2];
    assign wr       = ack & wbs_we_i;
    assign rd       = ack & ~wbs_we_i;
    assign m2s_push = wr & (off == OFF_DATA);
    assign s2m_pop  = rd & (off == OFF_DATA);
    assign st_wr    = wr & (off == OFF_STATUS);
    assign ctrl_wr  = wr & (off == OFF_CTRL) & wbs_sel_i[0];
    assign flush    = ctrl_wr & wbs_dat_i[CTRL_FLUSH];

    mbx_fifo #(.DEPTH(DEPTH), .WIDTH(32)) u_m2s (
        .clk   (wb_clk_i),
        .rst   (wb_rst_i),
        .push  (m2s_push),
        .pop   (m2s_ready_i),
        .flush (flush),
        .wdata (wbs_dat_i),
        .rdata (m2s_data_o),
        .full  (m2s_full),
        .empty (m2s_empty),
        .count (m2s_count)
    );

    mbx_fifo #(.DEPTH(DEPTH), .WIDTH(32)) u_s2m (
        .clk   (wb_clk_i),
        .rst   (wb_rst_i),
        .push  (s2m_valid_i),
        .pop   (s2m_pop),
        .flush (flush),
        .wdata (s2m_data_i),
        .rdata (s2m_head),
        .full  (s2m_full),
        .empty (s2m_empty),
        .count (s2m_count)
    );

    assign m2s_valid_o = ~m2s_empty;
    assign s2m_ready_o = ~s2m_full;

    // Sticky flags: a set in the same cycle as a clear wins
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            irq_en <= 1'b0;
            ovf    <= 1'b0;
            unf    <= 1'b0;
            irq_o  <= 1'b0;
        end else begin
            ovf   <= (m2s_push & m2s_full)  | (ovf & ~(st_wr & wbs_dat_i[ST_OVF]));
            unf   <= (s2m_pop  & s2m_empty) | (unf & ~(st_wr & wbs_dat_i[ST_UNF]));
            irq_o <= irq_en & ~s2m_empty;
            if (ctrl_wr) irq_en <= wbs_dat_i[CTRL_IRQ_EN];
        end
    end

    always_comb begin
        status                     = '0;
        status[ST_M2S_FULL]        = m2s_full;
        status[ST_M2S_EMPTY]       = m2s_empty;
        status[ST_S2M_FULL]        = s2m_full;
        status[ST_S2M_EMPTY]       = s2m_empty;
        status[ST_OVF]             = ovf;
        status[ST_UNF]             = unf;
        status[ST_M2S_CNT +: 4]    = m2s_count[3:0];
        status[ST_S2M_CNT +: 4]    = s2m_count[3:0];
    end

    always_comb begin
        rdata = '0;
        if (rd) begin
            case (off)
                OFF_DATA:   rdata = s2m_head;
                OFF_STATUS: rdata = status;
                OFF_CTRL:   rdata[CTRL_IRQ_EN] = irq_en;
                OFF_RSVD:   rdata = '0;
                default:    rdata = '0;
            endcase
        end
    end

    assign wbs_ack_o = ack;
    assign wbs_dat_o = rdata;

    assign unused = ^{wbs_adr_i[1:0], wbs_sel_i[3:1], m2s_count[4], s2m_count[4]};

endmodule

// File: tb/tb_wb_mailbox.sv
// Bench for wb_mailbox: register-access vector table, directed corner cases,
// and random traffic scored every cycle against a queue-based model.
module tb_wb_mailbox;
    localparam logic [31:0] BASE  = 32'h3000_0000;
    localparam int          DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [3:0]  sel = 4'h0;
    logic [31:0] wdat = '0, adr = '0;
    logic        ack;
    logic [31:0] rdat, m2s_data, s2m_data = '0;
    logic        m2s_valid, m2s_ready = 1'b0, s2m_valid = 1'b0, s2m_ready, irq;

    always #5 clk = ~clk;

    wb_mailbox #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .wbs_stb_i   (stb),
        .wbs_cyc_i   (cyc),
        .wbs_we_i    (we),
        .wbs_sel_i   (sel),
        .wbs_dat_i   (wdat),
        .wbs_adr_i   (adr),
        .wbs_ack_o   (ack),
        .wbs_dat_o   (rdat),
        .m2s_data_o  (m2s_data),
        .m2s_valid_o (m2s_valid),
        .m2s_ready_i (m2s_ready),
        .s2m_data_i  (s2m_data),
        .s2m_valid_i (s2m_valid),
        .s2m_ready_o (s2m_ready),
        .irq_o       (irq)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] mq[$];
    logic [31:0] sq[$];
    bit          ovf_m, unf_m, ien_m, irq_m, ack_m;
    bit          acc, wrd, rdd, fl, stw, ctw;
    int          nm, ns;
    logic [31:0] exp_rd, st;

    always @(posedge clk) begin
        if (rst) begin
            mq.delete(); sq.delete();
            ovf_m = 0; unf_m = 0; ien_m = 0; irq_m = 0; ack_m = 0;
        end else begin
            acc = ack_m;
            nm  = mq.size();
            ns  = sq.size();
            wrd = acc && we && adr[3:2] == 2'd0;
            rdd = acc && !we && adr[3:2] == 2'd0;
            stw = acc && we && adr[3:2] == 2'd1;
            ctw = acc && we && adr[3:2] == 2'd2 && sel[0];
            fl  = ctw && wdat[1];
            irq_m = ien_m && ns > 0;
            if (wrd && nm == DEPTH)      ovf_m = 1;
            else if (stw && wdat[8])     ovf_m = 0;
            if (rdd && ns == 0)          unf_m = 1;
            else if (stw && wdat[9])     unf_m = 0;
            if (ctw) ien_m = wdat[0];
            if (fl) begin
                mq.delete(); sq.delete();
            end else begin
                if (m2s_ready && nm > 0)    void'(mq.pop_front());
                if (wrd && nm < DEPTH)      mq.push_back(wdat);
                if (rdd && ns > 0)          void'(sq.pop_front());
                if (s2m_valid && ns < DEPTH) sq.push_back(s2m_data);
            end
            ack_m = acc ? 1'b0 : (cyc && stb && adr[31:4] == BASE[31:4]);
        end
        #1;
        st = '0;
        st[0]     = (mq.size() == DEPTH);
        st[1]     = (mq.size() == 0);
        st[2]     = (sq.size() == DEPTH);
        st[3]     = (sq.size() == 0);
        st[8]     = ovf_m;
        st[9]     = unf_m;
        st[15:12] = 4'(mq.size());
        st[19:16] = 4'(sq.size());
        exp_rd = '0;
        if (ack_m && !we) begin
            case (adr[3:2])
                2'd0:    exp_rd = (sq.size() > 0) ? sq[0] : 32'h0;
                2'd1:    exp_rd = st;
                2'd2:    exp_rd = {31'h0, ien_m};
                default: exp_rd = 32'h0;
            endcase
        end
        chk("mon_ack", {31'h0, ack}, {31'h0, ack_m});
        chk("mon_rdata", rdat, exp_rd);
        chk("mon_m2s_valid", {31'h0, m2s_valid}, {31'h0, mq.size() > 0});
        if (mq.size() > 0) chk("mon_m2s_data", m2s_data, mq[0]);
        else if (rst)      chk("mon_m2s_data_rst", m2s_data, 32'h0);
        chk("mon_s2m_ready", {31'h0, s2m_ready}, {31'h0, sq.size() < DEPTH});
        chk("mon_irq", {31'h0, irq}, {31'h0, irq_m});
    end

    // ---------------- bus tasks ----------------
    task automatic wb(input bit w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, output logic [31:0] rd, output int lat);
        @(negedge clk);
        cyc = 1; stb = 1; we = w; adr = a; wdat = d; sel = s;
        rd = '0; lat = -1;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk); #1;
            if (ack) begin lat = i; rd = rdat; break; end
        end
        if (lat > 0) @(posedge clk);
        @(negedge clk);
        cyc = 0; stb = 0; we = 0;
    endtask

    task automatic wr(input logic [3:0] off, input logic [31:0] d, input string name);
        logic [31:0] rd; int lat;
        wb(1, BASE + {28'h0, off}, d, 4'hF, rd, lat);
        chk({name, "_lat"}, lat, 1);
    endtask

    task automatic rdreg(input logic [3:0] off, input logic [31:0] exp, input string name);
        logic [31:0] rd; int lat;
        wb(0, BASE + {28'h0, off}, 32'h0, 4'hF, rd, lat);
        chk({name, "_lat"}, lat, 1);
        chk(name, rd, exp);
    endtask

    typedef struct {
        bit          we;
        logic [3:0]  off;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[22];

    initial begin
        logic [31:0] rd, d, a;
        int          lat, off;
        bit          w;
        logic [3:0]  s;

        tbl[0]  = '{0, 4'h4, 32'h0,         4'hF, 32'h0000_000A};
        tbl[1]  = '{0, 4'h8, 32'h0,         4'hF, 32'h0};
        tbl[2]  = '{1, 4'h8, 32'h1,         4'hF, 32'h0};
        tbl[3]  = '{0, 4'h8, 32'h0,         4'hF, 32'h1};
        tbl[4]  = '{1, 4'h8, 32'h0,         4'hE, 32'h0};
        tbl[5]  = '{0, 4'h8, 32'h0,         4'hF, 32'h1};
        tbl[6]  = '{1, 4'h8, 32'h0,         4'h1, 32'h0};
        tbl[7]  = '{0, 4'h8, 32'h0,         4'hF, 32'h0};
        tbl[8]  = '{1, 4'hC, 32'hFFFF_FFFF, 4'hF, 32'h0};
        tbl[9]  = '{0, 4'hC, 32'h0,         4'hF, 32'h0};
        tbl[10] = '{0, 4'h0, 32'h0,         4'hF, 32'h0};
        tbl[11] = '{0, 4'h4, 32'h0,         4'hF, 32'h0000_020A};
        tbl[12] = '{1, 4'h4, 32'h100,       4'hF, 32'h0};
        tbl[13] = '{0, 4'h4, 32'h0,         4'hF, 32'h0000_020A};
        tbl[14] = '{1, 4'h4, 32'h200,       4'hF, 32'h0};
        tbl[15] = '{0, 4'h4, 32'h0,         4'hF, 32'h0000_000A};
        tbl[16] = '{1, 4'h0, 32'hCAFE_F00D, 4'h0, 32'h0};
        tbl[17] = '{1, 4'h0, 32'h0BAD_BEEF, 4'hF, 32'h0};
        tbl[18] = '{0, 4'h4, 32'h0,         4'hF, 32'h0000_2008};
        tbl[19] = '{1, 4'h8, 32'h2,         4'h1, 32'h0};
        tbl[20] = '{0, 4'h4, 32'h0,         4'hF, 32'h0000_000A};
        tbl[21] = '{0, 4'h8, 32'h0,         4'hF, 32'h0};

        repeat (3) @(negedge clk);
        chk("rst_s2m_ready", {31'h0, s2m_ready}, 32'h1);
        chk("rst_m2s_valid", {31'h0, m2s_valid}, 32'h0);
        rst = 0;

        // Single DATA write reaches the SoC side
        wr(4'h0, 32'h1234_5678, "s27_wr");
        chk("s27_m2s_valid", {31'h0, m2s_valid}, 32'h1);
        chk("s27_m2s_data", m2s_data, 32'h1234_5678);
        rdreg(4'h4, 32'h0000_1008, "s27_status");
        wr(4'h8, 32'h2, "flush0");

        for (int i = 0; i < 22; i++) begin
            wb(tbl[i].we, BASE + {28'h0, tbl[i].off}, tbl[i].dat, tbl[i].sel, rd, lat);
            chk($sformatf("tbl%0d_lat", i), lat, 1);
            if (!tbl[i].we) chk($sformatf("tbl%0d_rd", i), rd, tbl[i].exp);
        end

        // Overflow: five writes into a depth-4 FIFO with the SoC stalled
        for (int i = 0; i < 5; i++) wr(4'h0, 32'h100 + i, $sformatf("s28_wr%0d", i));
        rdreg(4'h4, 32'h0000_4109, "s28_status");
        chk("s28_head", m2s_data, 32'h100);
        m2s_ready = 1;
        repeat (5) @(negedge clk);
        m2s_ready = 0;
        chk("s28_drained", {31'h0, m2s_valid}, 32'h0);
        wr(4'h4, 32'h100, "s28_clr");
        rdreg(4'h4, 32'h0000_000A, "s28_status_clr");

        // IRQ on SoC push, cleared after the mailbox read
        wr(4'h8, 32'h1, "s29_ien");
        @(negedge clk);
        s2m_data = 32'hA5A5_0001; s2m_valid = 1;
        @(negedge clk);
        s2m_valid = 0;
        @(posedge clk); #1;
        chk("s29_irq_hi", {31'h0, irq}, 32'h1);
        rdreg(4'h0, 32'hA5A5_0001, "s29_data");
        repeat (2) @(negedge clk);
        chk("s29_irq_lo", {31'h0, irq}, 32'h0);
        wr(4'h8, 32'h0, "s29_idis");

        // Outside the window: never acked
        wb(1, BASE + 32'h10, 32'hDEAD_BEEF, 4'hF, rd, lat);
        chk("s31_noack", lat, -1);
        wb(0, BASE - 32'h4, 32'h0, 4'hF, rd, lat);
        chk("s31_noack_below", lat, -1);

        // Random traffic scored by the monitor
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            m2s_ready = 1'($urandom_range(0, 1));
            s2m_valid = ($urandom_range(0, 2) == 0);
            s2m_data  = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                off = $urandom_range(0, 3) * 4;
                w   = 1'($urandom_range(0, 1));
                d   = $urandom;
                if (off == 8 && $urandom_range(0, 3) != 0) d[1] = 1'b0;
                s   = 4'($urandom_range(0, 15));
                a   = ($urandom_range(0, 15) == 0) ? BASE + 32'h20 + off : BASE + off;
                wb(w, a, d, s, rd, lat);
            end
        end
        @(negedge clk);
        m2s_ready = 0; s2m_valid = 0;

        // Reset while an ack is pending with both FIFOs loaded
        wr(4'h0, 32'h11, "s32_fill");
        @(negedge clk);
        s2m_data = 32'h22; s2m_valid = 1;
        @(negedge clk);
        s2m_valid = 0;
        cyc = 1; stb = 1; we = 0; adr = BASE + 32'h4; sel = 4'hF;
        @(posedge clk); #1;
        chk("s32_ack_pending", {31'h0, ack}, 32'h1);
        #2 rst = 1;
        #1 chk("s32_ack_killed", {31'h0, ack}, 32'h0);
        @(negedge clk);
        cyc = 0; stb = 0;
        repeat (2) @(negedge clk);
        rst = 0;
        repeat (4) begin
            @(posedge clk); #1;
            chk("s32_no_late_ack", {31'h0, ack}, 32'h0);
        end
        rdreg(4'h4, 32'h0000_000A, "s32_status");
        rdreg(4'h8, 32'h0, "s32_ctrl");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL timeout: simulation did not finish");
        fails++;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "timeout");
    end

endmodule
